spi_txn_arbiter: RTL

- Sequences multi-byte SPI transactions on top of the single-byte spi_master and shares that master between two requesters (REQ0, REQ1) using round-robin arbitration.
- Owns a per-requester active-low chip select, held for the whole burst with programmable setup/hold gaps.
- Sits between the SD-card / sensor clients and spi_master.

---
 rtl/spi_txn_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_txn_arbiter.sv
// ============================================================================
//  Module   : spi_txn_arbiter
//  Purpose  : Multi-byte SPI transaction sequencer that shares one single-byte
//             spi_master between two requesters using round-robin arbitration.
//             Drives a per-requester active-low chip select that stays low for
//             the whole burst, framed by programmable setup and hold gaps.
//  Options  : `define SPI_TXN_TIMEOUT_EN adds a per-byte watchdog that aborts
//             a byte after TIMEOUT_CYC cycles without m_new_data (err pulse,
//             no rx_valid, burst closes normally through HOLD).
//  Ports    : clk, rst (async, active-high)
//             req[1:0]          level requests
//             len0/len1         burst length minus one, per requester
//             tx_data0/tx_data1 next byte to send, per requester
//             tx_ready[1:0]     pulse: owner's tx byte consumed
//             rx_data, rx_valid received byte and per-requester valid pulse
//             done[1:0]         pulse: burst finished
//             grant[1:0]        one-hot owner, 0 when idle
//             cs_n[1:0]         active-low chip selects
//             err               watchdog abort pulse (0 without the option)
//             m_start, m_data_in, m_busy, m_new_data, m_data_out: spi_master
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_txn_arbiter #(
  parameter int LEN_W       = 8,
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       tx_data0,
  input  logic [7:0]       tx_data1,
  output logic [1:0]       tx_ready,
  output logic [7:0]       rx_data,
  output logic [1:0]       rx_valid,
  output logic [1:0]       done,
  output logic [1:0]       grant,
  output logic [1:0]       cs_n,
  output logic             err,
  output logic             m_start,
  output logic [7:0]       m_data_in,
  input  logic             m_busy,
  input  logic             m_new_data,
  input  logic [7:0]       m_data_out
);

  localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [GAP_W-1:0]   r_gap;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic               r_owner;
  logic               r_last;
  logic [1:0]         r_grant;
  logic [1:0]         r_cs_n;
  logic [7:0]         r_rx_data;
  logic [1:0]         r_rx_valid;
  logic [1:0]         r_done;

  logic               w_win;
  logic               w_take;
  logic               w_issue;
  logic               w_byte_done;
  logic               w_end;
  logic               w_timeout;
  logic [1:0]         w_owner_oh;

`ifdef SPI_TXN_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0]  r_wdog;
  logic               r_err;
`endif

  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

  // Next-state and strobe decode
  always_comb begin
    w_state_next = r_state;
    w_win        = 1'b0;
    w_take       = 1'b0;
    w_issue      = 1'b0;
    w_byte_done  = 1'b0;
    w_end        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          w_take       = 1'b1;
          // On a tie the requester that did not own the last burst wins;
          // with a single request req[1] already names the winner.
          w_win        = (req == 2'b11) ? ~r_last : req[1];
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_gap == GAP_W'(CS_SETUP - 1)) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!m_busy) begin
          w_issue      = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (m_new_data) begin
          w_byte_done  = 1'b1;
          // Compare before increment so a full-length burst never wraps
          w_state_next = (r_cnt == r_len) ? ST_HOLD : ST_ISSUE;
        end
`ifdef SPI_TXN_TIMEOUT_EN
        else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_HOLD;
        end
`endif
      end
      ST_HOLD: begin
        if (r_gap == GAP_W'(CS_HOLD - 1)) begin
          w_end        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_grant    <= 2'b00;
      r_cs_n     <= 2'b11;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 2'b00;
      r_done     <= 2'b00;
    end else begin
      r_rx_valid <= 2'b00;
      r_done     <= 2'b00;

      // Gap timer only runs while dwelling in SETUP or HOLD
      if ((r_state == ST_SETUP || r_state == ST_HOLD) && (w_state_next == r_state))
        r_gap <= r_gap + GAP_W'(1);
      else
        r_gap <= '0;

      if (w_take) begin
        r_owner <= w_win;
        r_len   <= w_win ? len1 : len0;
        r_cnt   <= '0;
        r_grant <= w_win ? 2'b10 : 2'b01;
        r_cs_n  <= w_win ? 2'b01 : 2'b10;
      end

      if (w_byte_done) begin
        r_rx_data  <= m_data_out;
        r_rx_valid <= w_owner_oh;
        if (r_cnt != r_len) r_cnt <= r_cnt + LEN_W'(1);
      end

      if (w_end) begin
        r_cs_n  <= 2'b11;
        r_grant <= 2'b00;
        r_done  <= w_owner_oh;
        r_last  <= r_owner;
      end
    end
  end

`ifdef SPI_TXN_TIMEOUT_EN
  // Watchdog restarts with every issued byte so it is zero on WAIT entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_issue)
        r_wdog <= '0;
      else if (r_state == ST_WAIT)
        r_wdog <= r_wdog + WDOG_W'(1);
    end
  end
  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC ^ w_timeout;
  assign err = 1'b0;
`endif

  // Byte launch is combinational on the ISSUE cycle so tx_data is sampled
  // exactly when the master accepts it.
  assign m_start   = w_issue;
  assign tx_ready  = w_issue ? w_owner_oh : 2'b00;
  assign m_data_in = w_issue ? (r_owner ? tx_data1 : tx_data0) : 8'h00;

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign done     = r_done;
  assign grant    = r_grant;
  assign cs_n     = r_cs_n;

endmodule

`default_nettype wire
